// File: rtl/mc_sequencer_pkg.sv
// Shared phase encodings and helpers for the multi-cycle instruction sequencer.
package mc_sequencer_pkg;

    localparam logic [2:0] ST_IF  = 3'd0;
    localparam logic [2:0] ST_ID  = 3'd1;
    localparam logic [2:0] ST_EX  = 3'd2;
    localparam logic [2:0] ST_MEM = 3'd3;
    localparam logic [2:0] ST_WB  = 3'd4;

    typedef struct packed {
        logic is_mem;
        logic is_wb;
    } inst_flags_t;

    // Zero latency still costs one EX cycle; anything longer is capped.
    function automatic logic [3:0] eff_lat(input logic [3:0] lat, input logic [3:0] max_lat);
        if (lat == 4'd0) begin
            return 4'd1;
        end
        if (lat > max_lat) begin
            return max_lat;
        end
        return lat;
    endfunction

endpackage

// File: rtl/mc_sequencer_perf_cnt.sv
// Free-running cycle counter and retired-instruction counter.
module mc_perf_cnt #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             commit,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instret_cnt
);

    logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d;
    logic [CNT_W-1:0] instret_cnt_q, instret_cnt_d;

    always_comb begin
        cycle_cnt_d   = cycle_cnt_q + 1'b1;
        instret_cnt_d = instret_cnt_q;
        if (commit) begin
            instret_cnt_d = instret_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cycle_cnt_q   <= '0;
            instret_cnt_q <= '0;
        end else begin
            cycle_cnt_q   <= cycle_cnt_d;
            instret_cnt_q <= instret_cnt_d;
        end
    end

    assign cycle_cnt   = cycle_cnt_q;
    assign instret_cnt = instret_cnt_q;

endmodule

// File: rtl/mc_sequencer.sv
// Five-phase IF/ID/EX/MEM/WB instruction sequencer with variable EX latency.
module mc_sequencer
    import mc_sequencer_pkg::*;
#(
    parameter int EX_MAX_LAT = 4,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             hold,
    input  logic             inst_ok,
    input  logic [3:0]       id_ex_lat,
    input  logic             id_is_mem,
    input  logic             id_is_wb,
    input  logic             data_ok,
    output logic             if_req,
    output logic             data_req,
    output logic [2:0]       state,
    output logic             ex_last,
    output logic             commit,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instret_cnt
);

    localparam logic [3:0] MAX_LAT = 4'(EX_MAX_LAT);

    logic [2:0]  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [3:0]  lat_q, lat_d;
    inst_flags_t flags_q, flags_d;
    logic [3:0]  ex_cur;

    // A zero counter in EX marks the entry cycle, where lat_q is loaded.
    assign ex_cur = (cnt_q == 4'd0) ? lat_q : cnt_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        lat_d   = lat_q;
        flags_d = flags_q;
        if (state_q > ST_WB) begin
            state_d = ST_IF;
        end else if (!hold) begin
            case (state_q)
                ST_IF: begin
                    if (inst_ok) begin
                        state_d = ST_ID;
                    end
                end
                ST_ID: begin
                    lat_d   = eff_lat(id_ex_lat, MAX_LAT);
                    flags_d = '{is_mem: id_is_mem, is_wb: id_is_wb};
                    cnt_d   = 4'd0;
                    state_d = ST_EX;
                end
                ST_EX: begin
                    cnt_d = ex_cur - 4'd1;
                    if (ex_cur == 4'd1) begin
                        if (flags_q.is_mem) begin
                            state_d = ST_MEM;
                        end else if (flags_q.is_wb) begin
                            state_d = ST_WB;
                        end else begin
                            state_d = ST_IF;
                        end
                    end
                end
                ST_MEM: begin
                    if (data_ok) begin
                        state_d = flags_q.is_wb ? ST_WB : ST_IF;
                    end
                end
                default: begin
                    state_d = ST_IF;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IF;
            cnt_q   <= '0;
            lat_q   <= '0;
            flags_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            lat_q   <= lat_d;
            flags_q <= flags_d;
        end
    end

    assign state    = state_q;
    assign if_req   = !hold && (state_q == ST_IF);
    assign data_req = !hold && (state_q == ST_MEM);
    assign ex_last  = !hold && (state_q == ST_EX) && (ex_cur == 4'd1);
    assign commit   = !hold && ((state_q == ST_WB)
                              || (ex_last && !flags_q.is_mem && !flags_q.is_wb)
                              || ((state_q == ST_MEM) && data_ok && !flags_q.is_wb));

    mc_perf_cnt #(
        .CNT_W(CNT_W)
    ) u_perf_cnt (
        .clk         (clk),
        .resetn      (resetn),
        .commit      (commit),
        .cycle_cnt   (cycle_cnt),
        .instret_cnt (instret_cnt)
    );

endmodule
